line_buffer_3row: RTL
=====================

Name: line_buffer_3row

Overview:
- Upstream neighbour of the 3x3 cross-min (erosion) window stage.
- Takes a raster pixel stream, one pixel per valid cycle, and emits three vertically aligned pixels: rows r-2, r-1 and r of the same column.
- Outputs drive the window stage's din1/din2/din3 and valid_in directly.
- Stores two previous rows in one packed line RAM.

Parameters:
- PIC_WIDTH, 250: pixels per row.
- PIC_HEIGHT, 250: rows per frame.
- WIDTH, 24: pixel width in bits (RGB888).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: reset; one clock; reset is synchronous and active-high.
- sof, input, 1: start-of-frame; sampled only when valid_in=1; marks that pixel as row 0, col 0.
- valid_in, input, 1: din carries a pixel this cycle.
- din, input, WIDTH: input pixel.
- valid_out, output, 1: dout1..3 form a valid column triple this cycle.
- dout1, output, WIDTH: pixel from row r-2 (oldest row).
- dout2, output, WIDTH: pixel from row r-1.
- dout3, output, WIDTH: pixel from row r (current row).

Behaviour:
- Reset:
  - valid_out, dout1, dout2 and dout3 are 0.
  - col=0, row=0.
  - RAM contents are not cleared.
- Counters:
  - col is $clog2(PIC_WIDTH) bits; row is $clog2(PIC_HEIGHT) bits.
  - Both advance only on valid_in=1.
  - col wraps from PIC_WIDTH-1 to 0 and increments row at that point.
  - row wraps from PIC_HEIGHT-1 to 0, which is the frame end.
- Storage:
  - RAM depth is PIC_WIDTH; each word is {row r-1 pixel, row r-2 pixel}, 2*WIDTH bits.
  - On valid_in at column c: q = mem[c] (read-before-write), then mem[c] <= {din, q_hi}.
- Latency is one cycle, registered outputs. At t+1 after an accepted pixel:
  - dout3 = din.
  - dout2 = q_hi if row>=1, else 0.
  - dout1 = q_lo if row>=2, else 0.
  - valid_out = 1 iff row>=2. Row is the value at time t, before any increment.
- valid_in=0:
  - valid_out=0 next cycle.
  - dout1..3, col and row hold.
  - No RAM write.
  - Gaps (h-blank or stalls) are allowed anywhere; the column position is preserved across them.
- sof=1 with valid_in=1:
  - The pixel is processed as row 0, col 0, regardless of current counters.
  - Next col=1 (or 0 if PIC_WIDTH=1); row=0.
  - Stale RAM contents are masked by the row>=1 and row>=2 rules.
- sof with valid_in=0: ignored.
- Reset mid-frame: counters and outputs return to reset values on the next edge; the stream resumes as row 0.
- No backpressure: the downstream stage always accepts.

Decomposition:
- Shared package (img_pkg) holds:
  - PIC_WIDTH_DEF=250, PIC_HEIGHT_DEF=250, PIX_W=24.
  - A pixel typedef of PIX_W bits.
- Sub-module line_ram (parameters DEPTH, DW):
  - Single port, synchronous write.
  - Registered read-before-write output.
  - Inferrable as block RAM.
- Top level holds the counters, masking, din delay register and valid pipeline.

Test Plan (WIDTH=8, PIC_WIDTH=4, PIC_HEIGHT=4, pixel value = row*16+col):
- Reset: assert rst mid-stream for 2 cycles -> valid_out=0 and dout1..3=0 the cycle after; the next pixel with valid_in is treated as row 0.
- Fill: stream rows 0 and 1 with sof on the first pixel.
  - valid_out stays 0 throughout.
  - During row 1, dout2 = 0x00..0x03 aligned with dout3 = 0x10..0x13.
  - dout1 = 0 throughout.
- Steady state: accept pixel 0x21 -> the next cycle shows valid_out=1, dout1=0x01, dout2=0x11, dout3=0x21.
- Stall: drop valid_in for 3 cycles after 0x22.
  - valid_out=0 during the gap; dout1..3 hold 0x02/0x12/0x22.
  - Resuming with 0x23 yields 0x03/0x13/0x23 with valid_out=1.
- Frame wrap: after 0x33, feed the next frame's first pixel 0x00 without sof -> valid_out=0, dout1=dout2=0, dout3=0x00.
- sof mid-frame: assert sof with the pixel at row 2, col 2 -> counters restart.
  - valid_out stays 0 for the next 8 accepted pixels.
  - The 9th accepted pixel (row 2, col 0) gives valid_out=1.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline constants and the pixel type used by the erosion front end.
package img_pkg;

    localparam int PIC_WIDTH_DEF  = 250;
    localparam int PIC_HEIGHT_DEF = 250;
    localparam int PIX_W          = 24;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// Single-port line RAM holding {row r-1, row r-2} per column; a write shifts the
// new pixel into the upper half and ages the old upper half into the lower half.
module line_ram #(
    parameter int DEPTH = 250,
    parameter int DW    = 48,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW/2-1:0] din,
    output logic [DW-1:0]   q
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] q_r;

    // Read-before-write; the read port only updates on an accepted pixel so it holds across gaps.
    always_ff @(posedge clk) begin
        if (we) begin
            q_r         <= mem_r[addr];
            mem_r[addr] <= {din, mem_r[addr][DW-1:DW/2]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: emits the column triple (r-2, r-1, r) one cycle after each
// accepted raster pixel, feeding the 3x3 cross-min window stage.
module line_buffer_3row
    import img_pkg::*;
#(
    parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
    parameter int PIC_HEIGHT = PIC_HEIGHT_DEF,
    parameter int WIDTH      = PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);

    localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

    logic [CW-1:0]      col_r, eff_col_s, col_nxt_s;
    logic [RW-1:0]      row_r, eff_row_s, row_nxt_s;
    logic [WIDTH-1:0]   din_r;
    logic               ge1_r, ge2_r, valid_r;
    logic               ge1_s, ge2_s;
    logic [2*WIDTH-1:0] ram_q_s;

    // Effective position of the incoming pixel (sof forces row 0, col 0) and the advanced counters.
    always_comb begin
        eff_col_s = col_r;
        eff_row_s = row_r;
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (sof && valid_in) begin
            eff_col_s = {CW{1'b0}};
            eff_row_s = {RW{1'b0}};
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
        if (eff_col_s == COL_LAST) begin
            col_nxt_s = {CW{1'b0}};
            if (eff_row_s == ROW_LAST) begin
                row_nxt_s = {RW{1'b0}};
            end else begin
                row_nxt_s = eff_row_s + RW'(1);
            end
        end else begin
            col_nxt_s = eff_col_s + CW'(1);
            row_nxt_s = eff_row_s;
        end
        if (sof && valid_in) begin
            row_nxt_s = {RW{1'b0}};
        end else begin
            row_nxt_s = row_nxt_s;
        end
        ge1_s = (eff_row_s != {RW{1'b0}});
        ge2_s = (eff_row_s > RW'(1));
    end

    // Position counters, current-row delay register and row-validity masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r   <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            din_r   <= {WIDTH{1'b0}};
            ge1_r   <= 1'b0;
            ge2_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (valid_in) begin
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
            din_r   <= din;
            ge1_r   <= ge1_s;
            ge2_r   <= ge2_s;
            valid_r <= ge2_s;
        end else begin
            valid_r <= 1'b0;
        end
    end

    line_ram #(
        .DEPTH (PIC_WIDTH),
        .DW    (2 * WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (valid_in && !rst),
        .addr (eff_col_s),
        .din  (din),
        .q    (ram_q_s)
    );

    // Rows not yet filled this frame read stale RAM, so they are forced to zero.
    assign valid_out = valid_r;
    assign dout3     = din_r;
    assign dout2     = ge1_r ? ram_q_s[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
    assign dout1     = ge2_r ? ram_q_s[WIDTH-1:0]       : {WIDTH{1'b0}};

endmodule
